bidirect_reg_seq: RTL and testbench
===================================

// Module: bidirect_reg_seq
// PURPOSE
//   Command sequencer directly upstream of the 4-bit bidirectional shift register (bidirect_reg).
//   Accepts a {data, direction, shift count, fill bit} command on a valid/ready handshake.
//   Drives the register's sel/left_in/right_in/parallel_in: one parallel load, then N shifts.
//   Reads the register's q back and emits each bit as it leaves (serialiser front end).
// PARAMETERS
//   WIDTH  4                     register width; must match bidirect_reg
//   CNT_W  $clog2(WIDTH+1) (=3)  width of shift-count field and internal counter
// PORTS
//   clk          in   1      rising-edge clock, shared with bidirect_reg
//   rst_n        in   1      reset, asynchronous, active-low
//   cmd_valid    in   1      command present
//   cmd_ready    out  1      sequencer can accept a command
//   cmd_data     in   WIDTH  word to parallel-load
//   cmd_dir      in   1      0: shift toward LSB (sel=01); 1: shift toward MSB (sel=10)
//   cmd_shamt    in   CNT_W  number of shifts; 0..WIDTH, larger values clamp to WIDTH
//   cmd_fill     in   1      serial bit shifted in on every shift of this command
//   sel          out  2      to bidirect_reg: 00 hold, 01 shift->LSB, 10 shift->MSB, 11 load
//   left_in      out  1      to bidirect_reg: enters q[WIDTH-1] when sel=01
//   right_in     out  1      to bidirect_reg: enters q[0] when sel=10
//   parallel_in  out  WIDTH  to bidirect_reg: load word, valid when sel=11
//   q_in         in   WIDTH  from bidirect_reg q
//   bit_valid    out  1      bit_out carries the bit leaving on this clock edge
//   bit_out      out  1      q_in[0] (dir 0) or q_in[WIDTH-1] (dir 1); 0 when !bit_valid
//   busy         out  1      command in progress (state != IDLE)
//   done         out  1      one-cycle pulse after the last shift
// BEHAVIOUR
//   - Reset (rst_n low, async): state IDLE, counter 0, captured fields 0.
//     Outputs: sel=00, left_in=right_in=0, parallel_in=0, bit_valid=bit_out=0, busy=0, done=0.
//     cmd_ready forced 0 while rst_n low.
//   - FSM: IDLE -> LOAD -> SHIFT (shamt cycles) -> DONE -> IDLE. Moore outputs.
//     sel, parallel_in, left_in and right_in decode only from state and captured registers.
//     There is no combinational path from cmd_* to register-control outputs.
//   - IDLE: sel=00, cmd_ready=1. Handshake completes on the edge where cmd_valid && cmd_ready.
//     That edge captures data, dir, clamped shamt and fill, and moves to LOAD.
//   - LOAD (1 cycle): sel=11, parallel_in=captured data. Register loads at the closing edge.
//     Counter set to shamt. Next state is SHIFT if shamt!=0, else DONE.
//   - SHIFT: sel=01 (dir 0) or 10 (dir 1).
//     left_in=fill when dir 0, right_in=fill when dir 1; the unused input is held 0.
//     bit_valid=1; bit_out taken combinationally from q_in (the bit lost at this edge).
//     Counter decrements each cycle; leave SHIFT for DONE when counter reaches 1.
//   - DONE (1 cycle): sel=00, done=1, busy=1, cmd_ready=0. Then IDLE.
//   - Latency: accept edge T -> sel=11 during cycle T+1.
//     Shifts occupy cycles T+2 .. T+1+shamt. done is high in cycle T+2+shamt.
//     cmd_ready returns high in cycle T+3+shamt. Busy time is shamt+2 cycles.
//   - cmd_* changes while busy are ignored. A command held valid is accepted on the first IDLE cycle.
//   - Reset mid-command: immediate IDLE. No done pulse, no further shifts.
//     The register contents are left as the register's own reset leaves them.
//   - Clamp: cmd_shamt > WIDTH is treated as WIDTH, so the register is fully flushed.
// STRUCTURE
//   - shift_reg_defs.vh (shared with bidirect_reg and benches):
//     SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11.
//     State codes ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE.
//   - One sub-module: bidirect_reg_seq_cnt.
//     CNT_W-bit loadable down-counter with load, dec and a last (==1) flag.
//     FSM and output decode stay in this module.
// TESTING (WIDTH=4; bench instantiates bidirect_reg_seq driving a real bidirect_reg)
//   1. rst_n=0 mid-run, cmd_valid=1 -> sel=00, busy=0, cmd_ready=0, bit_valid=0.
//      After release: cmd_ready=1.
//   2. data=1010, dir=0, shamt=4, fill=0 -> one sel=11 cycle, then four sel=01 cycles.
//      bit_out=0,1,0,1; q=0000; done on cycle 6 after accept.
//   3. data=1100, dir=1, shamt=2, fill=1 -> sel=10 x2, bit_out=1,1, q=0011, done once.
//   4. data=0110, shamt=0 -> LOAD then DONE, no bit_valid, q=0110 held (sel=00) afterwards.
//   5. data=1001, dir=0, shamt=7, fill=1 -> clamped to 4 shifts.
//      bit_out=1,0,0,1; q=1111; busy exactly 6 cycles.
//   6. rst_n low during 2nd shift of case 2 -> no done.
//      Next command (data=0101, dir=1, shamt=1) gives bit_out=0, q=1010.
//   7. cmd_valid held high with changing data while busy -> only the first word is loaded.
//      The second is accepted one cycle after done.

Source files
------------

// File: rtl/bidirect_reg_seq_pkg.sv
// Shared constants for the bidirectional shift register and its command sequencer.
package bidirect_reg_seq_pkg;

  localparam int DEF_WIDTH = 4;

  // Register control encodings seen by bidirect_reg
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;  // shift toward LSB, left_in enters MSB
  localparam logic [1:0] SEL_SHL  = 2'b10;  // shift toward MSB, right_in enters LSB
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // Sequencer state codes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Shift select for a command direction (0: toward LSB, 1: toward MSB)
  function automatic logic [1:0] shift_sel(input logic dir);
    return dir ? SEL_SHL : SEL_SHR;
  endfunction

endpackage

// File: rtl/bidirect_reg.sv
// 4-bit (parameterisable) bidirectional shift register with hold, shift and parallel load.
module bidirect_reg
  import bidirect_reg_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic             left_in,
  input  logic             right_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q
);

  // Register update selected by sel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_SHR:  q <= {left_in, q[WIDTH-1:1]};
        SEL_SHL:  q <= {q[WIDTH-2:0], right_in};
        SEL_LOAD: q <= parallel_in;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/bidirect_reg_seq_cnt.sv
// Loadable down-counter tracking the remaining shifts of the current command.
module bidirect_reg_seq_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // High while the final shift is in progress
  assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/bidirect_reg_seq.sv
// Command sequencer for bidirect_reg: parallel load followed by N shifts,
// emitting each bit as it falls off the end of the register.
module bidirect_reg_seq
  import bidirect_reg_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_shamt,
  input  logic             cmd_fill,
  output logic [1:0]       sel,
  output logic             left_in,
  output logic             right_in,
  output logic [WIDTH-1:0] parallel_in,
  input  logic [WIDTH-1:0] q_in,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] data_reg;
  logic             dir_reg;
  logic             fill_reg;
  logic [CNT_W-1:0] shamt_reg;
  logic [CNT_W-1:0] shamt_clamped;
  logic             accept;
  logic             cnt_last;
  logic [IDX_W-1:0] out_idx;

  assign accept        = (state_reg == ST_IDLE) && cmd_valid;
  assign shamt_clamped = (cmd_shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_shamt;

  // Capture the command fields on the accepting edge; held for the whole command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      dir_reg   <= 1'b0;
      fill_reg  <= 1'b0;
      shamt_reg <= '0;
    end else if (accept) begin
      data_reg  <= cmd_data;
      dir_reg   <= cmd_dir;
      fill_reg  <= cmd_fill;
      shamt_reg <= shamt_clamped;
    end
  end

  bidirect_reg_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_reg == ST_LOAD),
    .dec      (state_reg == ST_SHIFT),
    .load_val (shamt_reg),
    .last     (cnt_last)
  );

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_LOAD;
      ST_LOAD:  state_next = (shamt_reg != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt_last) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The bit leaving the register sits at the end opposite the fill
  assign out_idx = dir_reg ? IDX_W'(WIDTH - 1) : '0;

  // Register-control and serial outputs decoded from state and captured fields only
  always_comb begin
    sel         = SEL_HOLD;
    parallel_in = '0;
    left_in     = 1'b0;
    right_in    = 1'b0;
    bit_valid   = 1'b0;
    bit_out     = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        sel         = SEL_LOAD;
        parallel_in = data_reg;
      end
      ST_SHIFT: begin
        sel       = shift_sel(dir_reg);
        left_in   = !dir_reg && fill_reg;
        right_in  = dir_reg && fill_reg;
        bit_valid = 1'b1;
        bit_out   = q_in[out_idx];
      end
      default: ;
    endcase
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign cmd_ready = (state_reg == ST_IDLE) && rst_n;

endmodule

// File: tb/tb_bidirect_reg_seq.sv
// Bench for bidirect_reg_seq driving a real bidirect_reg.
module tb_bidirect_reg_seq;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_shamt = '0;
  logic          cmd_fill = 1'b0;
  logic [1:0]    sel;
  logic          left_in;
  logic          right_in;
  logic [W-1:0]  parallel_in;
  logic [W-1:0]  q;
  logic          bit_valid;
  logic          bit_out;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bidirect_reg_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_shamt(cmd_shamt), .cmd_fill(cmd_fill),
    .sel(sel), .left_in(left_in), .right_in(right_in), .parallel_in(parallel_in),
    .q_in(q), .bit_valid(bit_valid), .bit_out(bit_out), .busy(busy), .done(done)
  );

  bidirect_reg #(.WIDTH(W)) u_reg (
    .clk(clk), .rst_n(rst_n), .sel(sel), .left_in(left_in), .right_in(right_in),
    .parallel_in(parallel_in), .q(q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a command is a timeline of 1 load cycle, n shift cycles, 1 done cycle
  bit           m_active = 0;
  int           m_k = 0;
  int           m_n = 0;
  logic [W-1:0] m_data = '0;
  bit           m_dir = 0;
  bit           m_fill = 0;
  logic [W-1:0] mq = '0;

  initial begin
    logic [1:0]   e_sel;
    logic [W-1:0] e_pin;
    logic         e_l, e_r, e_bv, e_bo, e_busy, e_done, e_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 0;
        mq = '0;
      end
      e_sel = 2'b00; e_pin = '0; e_l = 0; e_r = 0; e_bv = 0; e_bo = 0;
      e_busy = 0; e_done = 0; e_rdy = 0;
      if (rst_n) begin
        if (!m_active) begin
          e_rdy = 1;
        end else begin
          e_busy = 1;
          if (m_k == 0) begin
            e_sel = 2'b11;
            e_pin = m_data;
          end else if (m_k <= m_n) begin
            e_sel = m_dir ? 2'b10 : 2'b01;
            e_bv  = 1;
            e_bo  = m_dir ? mq[W-1] : mq[0];
            e_l   = !m_dir && m_fill;
            e_r   = m_dir && m_fill;
          end else begin
            e_done = 1;
          end
        end
      end
      chk("m.sel", sel, e_sel);
      chk("m.parallel_in", parallel_in, e_pin);
      chk("m.left_in", left_in, e_l);
      chk("m.right_in", right_in, e_r);
      chk("m.bit_valid", bit_valid, e_bv);
      chk("m.bit_out", bit_out, e_bo);
      chk("m.busy", busy, e_busy);
      chk("m.done", done, e_done);
      chk("m.cmd_ready", cmd_ready, e_rdy);
      chk("m.q", q, mq);
      @(posedge clk);
      if (!rst_n) begin
        m_active = 0;
        mq = '0;
      end else if (m_active) begin
        if (m_k == 0)
          mq = m_data;
        else if (m_k <= m_n)
          mq = m_dir ? W'(mq * 2 + m_fill) : W'(mq / 2 + (m_fill ? 2 ** (W - 1) : 0));
        m_k++;
        if (m_k > m_n + 1) m_active = 0;
      end else if (cmd_valid) begin
        m_data   = cmd_data;
        m_dir    = cmd_dir;
        m_fill   = cmd_fill;
        m_n      = (int'(cmd_shamt) > W) ? W : int'(cmd_shamt);
        m_k      = 0;
        m_active = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check the serial bits, busy length, done timing and final q
  task automatic run_cmd(input string tag, input logic [W-1:0] d, input logic dir,
                         input logic [CW-1:0] sh, input logic fill, input int exp_n,
                         input logic [3:0] exp_bits, input logic [W-1:0] exp_q);
    int c, busy_cnt, done_cnt, done_c, nb;
    logic [3:0] bits;
    step();
    cmd_data = d; cmd_dir = dir; cmd_shamt = sh; cmd_fill = fill; cmd_valid = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!cmd_ready && c < 50);
    chk({tag, ".ready"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_c = 0; nb = 0; bits = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (bit_valid) begin
        bits = {bits[2:0], bit_out};
        nb++;
      end
      if (done) begin
        done_cnt++;
        done_c = i;
      end
      if (!busy) break;
    end
    chk({tag, ".nbits"}, nb, exp_n);
    chk({tag, ".bits"}, bits, exp_bits);
    chk({tag, ".busy_cycles"}, busy_cnt, exp_n + 2);
    chk({tag, ".done_count"}, done_cnt, 1);
    chk({tag, ".done_cycle"}, done_c, exp_n + 2);
    chk({tag, ".q"}, q, exp_q);
    $display("cmd %s data=%b dir=%0d shamt=%0d fill=%0d -> bits=%b q=%b", tag, d, dir, sh, fill, bits, q);
  endtask

  initial begin
    int acc_c, done_c;
    // Power-on reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("por.ready", cmd_ready, 1);

    // Case 1: reset asserted mid-command with cmd_valid held
    step();
    cmd_data = 4'b1010; cmd_dir = 0; cmd_shamt = 3'd4; cmd_fill = 0; cmd_valid = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("c1.sel", sel, 2'b00);
    chk("c1.busy", busy, 0);
    chk("c1.ready", cmd_ready, 0);
    chk("c1.bit_valid", bit_valid, 0);
    step();
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("c1.ready_after", cmd_ready, 1);
    $display("cmd c1 reset mid-command, sel=%b busy=%0d ready=%0d", sel, busy, cmd_ready);

    run_cmd("c2", 4'b1010, 1'b0, 3'd4, 1'b0, 4, 4'b0101, 4'b0000);
    run_cmd("c3", 4'b1100, 1'b1, 3'd2, 1'b1, 2, 4'b0011, 4'b0011);
    run_cmd("c4", 4'b0110, 1'b0, 3'd0, 1'b0, 0, 4'b0000, 4'b0110);
    repeat (3) @(negedge clk);
    chk("c4.q_held", q, 4'b0110);
    run_cmd("c5", 4'b1001, 1'b0, 3'd7, 1'b1, 4, 4'b1001, 4'b1111);

    // Case 6: reset during the second shift of the case-2 command
    step();
    cmd_data = 4'b1010; cmd_dir = 0; cmd_shamt = 3'd4; cmd_fill = 0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) @(negedge clk);
    chk("c6.second_shift_sel", sel, 2'b01);
    chk("c6.second_shift_bit", bit_out, 1);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("c6.no_done", done, 0);
      chk("c6.sel_hold", sel, 2'b00);
    end
    step();
    rst_n = 1'b1;
    run_cmd("c6b", 4'b0101, 1'b1, 3'd1, 1'b0, 1, 4'b0000, 4'b1010);

    // Case 7: cmd_valid held while busy with the data changing
    step();
    cmd_data = 4'b0011; cmd_dir = 0; cmd_shamt = 3'd1; cmd_fill = 0; cmd_valid = 1'b1;
    step();
    cmd_data = 4'b1110; cmd_dir = 1; cmd_shamt = 3'd2; cmd_fill = 0;
    acc_c = 0; done_c = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) chk("c7.first_load", parallel_in, 4'b0011);
      if (i == 2) chk("c7.first_q", q, 4'b0011);
      if (i == 4) chk("c7.ready_after_done", cmd_ready, 1);
      if (i > 1 && sel == 2'b11 && acc_c == 0) begin
        acc_c = i;
        chk("c7.second_load", parallel_in, 4'b1110);
      end
      if (done && done_c == 0) done_c = i;
      if (i == 5) begin
        #1;
        cmd_valid = 1'b0;
      end
    end
    chk("c7.done_cycle", done_c, 3);
    chk("c7.second_load_cycle", acc_c, 5);
    chk("c7.final_q", q, 4'b1000);
    $display("cmd c7 held valid: done at %0d, second load at %0d, q=%b", done_c, acc_c, q);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
